// File: rtl/nand_check_if.sv
// Bus between a NAND-gate sample source and the check monitor.
// The source (master) drives the samples; the monitor (slave) reports the run status.
interface nand_check_if;
    logic       start;
    logic       smp_valid;
    logic       a;
    logic       b;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic       timeout;
    logic [7:0] vec_cnt;
    logic [7:0] err_cnt;
    logic [7:0] first_err_idx;
    logic [2:0] first_err_vec;
    logic [3:0] cov;

    modport master (
        output start, smp_valid, a, b, y,
        input  busy, done, pass, timeout, vec_cnt, err_cnt,
               first_err_idx, first_err_vec, cov
    );

    modport slave (
        input  start, smp_valid, a, b, y,
        output busy, done, pass, timeout, vec_cnt, err_cnt,
               first_err_idx, first_err_vec, cov
    );
endinterface

// File: rtl/nand_check_monitor.sv
// Checks sampled {a,b,y} triples against y = ~(a&b) over one run of NUM_VEC samples,
// tracking errors, the first failing sample, input coverage and an idle timeout.
module nand_check_monitor #(
    parameter int NUM_VEC = 4,
    parameter int TIMEOUT = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    nand_check_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    typedef struct packed {
        logic a;
        logic b;
        logic y;
    } smp_t;

    localparam logic [7:0] LAST_VEC  = 8'(NUM_VEC - 1);
    localparam logic [7:0] LAST_IDLE = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    smp_t       smp;
    logic [7:0] vec_cnt, err_cnt, idle_cnt, first_err_idx;
    logic [2:0] first_err_vec;
    logic [3:0] cov;
    logic       timeout;
    logic       restart, sample, mismatch, idle_hit;

    always_comb begin
        smp      = '{a: bus.a, b: bus.b, y: bus.y};
        restart  = (state != S_RUN) && bus.start;
        sample   = (state == S_RUN) && bus.smp_valid;
        mismatch = smp.y != ~(smp.a & smp.b);
        idle_hit = (state == S_RUN) && !bus.smp_valid && (idle_cnt == LAST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN: begin
                if (sample && vec_cnt == LAST_VEC) state_nxt = S_DONE;
                else if (idle_hit)                 state_nxt = S_DONE;
            end
            S_DONE:  if (bus.start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt       <= '0;
            err_cnt       <= '0;
            idle_cnt      <= '0;
            first_err_idx <= '0;
            first_err_vec <= '0;
            cov           <= '0;
            timeout       <= 1'b0;
        end else if (restart) begin
            vec_cnt       <= '0;
            err_cnt       <= '0;
            idle_cnt      <= '0;
            first_err_idx <= '0;
            first_err_vec <= '0;
            cov           <= '0;
            timeout       <= 1'b0;
        end else if (sample) begin
            vec_cnt              <= vec_cnt + 8'd1;
            idle_cnt             <= '0;
            cov[{smp.a, smp.b}] <= 1'b1;
            if (mismatch) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                // err_cnt never returns to zero within a run, so zero marks the first mismatch
                if (err_cnt == 8'd0) begin
                    first_err_idx <= vec_cnt;
                    first_err_vec <= smp;
                end
            end
        end else if (state == S_RUN) begin
            idle_cnt <= idle_cnt + 8'd1;
            if (idle_hit) timeout <= 1'b1;
        end
    end

    assign bus.busy          = (state == S_RUN);
    assign bus.done          = (state == S_DONE);
    assign bus.pass          = (state == S_DONE) && (err_cnt == 8'd0) && !timeout && (cov == 4'hF);
    assign bus.timeout       = timeout;
    assign bus.vec_cnt       = vec_cnt;
    assign bus.err_cnt       = err_cnt;
    assign bus.first_err_idx = first_err_idx;
    assign bus.first_err_vec = first_err_vec;
    assign bus.cov           = cov;
endmodule

// File: tb/tb_nand_check_monitor.sv
// Randomized and directed bench for nand_check_monitor against a run-level model
// that keeps the samples of the current run in a queue and derives status from it.
module tb_nand_check_monitor;
    localparam int NV = 4;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    nand_check_if ifc();

    nand_check_monitor #(.NUM_VEC(NV), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // model: 0 idle, 1 run, 2 done
    int       m_state = 0;
    bit [2:0] m_smp[$];
    int       m_idle = 0;
    bit       m_to = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_bad(input bit [2:0] s);
        return s[0] != !(s[2] && s[1]);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_smp.delete();
        m_idle = 0;
        m_to = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit v, input bit [2:0] s);
        if (m_state == 1) begin
            if (v) begin
                m_smp.push_back(s);
                m_idle = 0;
                if (m_smp.size() == NV) m_state = 2;
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_state = 2;
                    m_to = 1'b1;
                end
            end
        end else if (st) begin
            model_reset();
            m_state = 1;
        end
    endtask

    task automatic check_all();
        int errs = 0;
        int fidx = 0;
        bit [2:0] fvec = 3'b000;
        bit [3:0] cv = 4'b0000;
        bit exp_pass;
        foreach (m_smp[i]) begin
            cv[m_smp[i][2:1]] = 1'b1;
            if (is_bad(m_smp[i])) begin
                if (errs == 0) begin
                    fidx = i;
                    fvec = m_smp[i];
                end
                errs++;
            end
        end
        if (errs > 255) errs = 255;
        exp_pass = (m_state == 2) && errs == 0 && !m_to && cv == 4'hF;
        chk("busy",  32'(ifc.busy),          32'(m_state == 1));
        chk("done",  32'(ifc.done),          32'(m_state == 2));
        chk("pass",  32'(ifc.pass),          32'(exp_pass));
        chk("tmo",   32'(ifc.timeout),       32'(m_to));
        chk("vec",   32'(ifc.vec_cnt),       32'(m_smp.size()));
        chk("err",   32'(ifc.err_cnt),       32'(errs));
        chk("fidx",  32'(ifc.first_err_idx), 32'(fidx));
        chk("fvec",  32'(ifc.first_err_vec), 32'(fvec));
        chk("cov",   32'(ifc.cov),           32'(cv));
    endtask

    // called at a negedge: drive, clock, update model, compare at the next negedge
    task automatic cyc(input bit st, input bit v, input bit [2:0] s);
        ifc.start = st;
        ifc.smp_valid = v;
        {ifc.a, ifc.b, ifc.y} = s;
        @(posedge clk);
        model_step(st, v, s);
        @(negedge clk);
        check_all();
    endtask

    task automatic run4(input bit [2:0] s0, s1, s2, s3);
        cyc(1, 0, 3'b000);
        cyc(0, 1, s0);
        cyc(0, 1, s1);
        cyc(0, 1, s2);
        cyc(0, 1, s3);
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.smp_valid = 1'b0;
        ifc.a = 1'b0;
        ifc.b = 1'b0;
        ifc.y = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cyc(0, 1, 3'b001);
        cyc(0, 1, 3'b110);

        // four correct vectors
        run4(3'b001, 3'b011, 3'b101, 3'b110);
        chk("good_pass", 32'(ifc.pass), 32'd1);
        chk("good_cov",  32'(ifc.cov),  32'hF);
        cyc(0, 1, 3'b111);

        // faulty gate
        run4(3'b001, 3'b010, 3'b101, 3'b111);
        chk("faulty_err",  32'(ifc.err_cnt),       32'd2);
        chk("faulty_fidx", 32'(ifc.first_err_idx), 32'd1);
        chk("faulty_fvec", 32'(ifc.first_err_vec), 32'b010);

        // incomplete coverage
        run4(3'b001, 3'b001, 3'b001, 3'b001);
        chk("cov_only", 32'(ifc.cov),  32'b0001);
        chk("cov_pass", 32'(ifc.pass), 32'd0);

        // timeout
        cyc(1, 1, 3'b000);
        cyc(0, 1, 3'b011);
        repeat (TO) cyc(0, 0, 3'b000);
        chk("to_done", 32'(ifc.done),    32'd1);
        chk("to_flag", 32'(ifc.timeout), 32'd1);
        chk("to_vec",  32'(ifc.vec_cnt), 32'd1);

        // start mid-run ignored, then restart from DONE
        cyc(1, 0, 3'b000);
        cyc(0, 1, 3'b001);
        cyc(1, 1, 3'b011);
        chk("mid_start_vec", 32'(ifc.vec_cnt), 32'd2);
        cyc(0, 1, 3'b100);
        cyc(0, 1, 3'b110);
        cyc(1, 1, 3'b000);
        chk("restart_vec", 32'(ifc.vec_cnt), 32'd0);

        // asynchronous reset mid-run
        cyc(0, 1, 3'b011);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        chk("arst_busy", 32'(ifc.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 3'b001);
        cyc(0, 1, 3'b011);

        // randomized runs
        for (int seg = 0; seg < 12; seg++) begin
            int pct = (seg % 3 == 2) ? 3 : 70;
            for (int i = 0; i < 50; i++) begin
                bit [2:0] s;
                s[2] = 1'($urandom_range(0, 1));
                s[1] = 1'($urandom_range(0, 1));
                s[0] = !(s[2] && s[1]);
                if ($urandom_range(0, 7) == 0) s[0] = !s[0];
                cyc($urandom_range(0, 19) == 0, $urandom_range(0, 99) < pct, s);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
